// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the fetch/decode path: opcode and function fields,
// next-PC source encodings and the control-transfer classification.
package cpu_isa_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_COP0    = 6'b010000;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_ERET    = 6'b011000;

    localparam logic [1:0] PCS_SEQ    = 2'b00;
    localparam logic [1:0] PCS_BR     = 2'b01;
    localparam logic [1:0] PCS_JR     = 2'b10;
    localparam logic [1:0] PCS_JMP    = 2'b11;

    typedef enum logic [2:0] {
        XK_NONE = 3'd0,
        XK_BR   = 3'd1,
        XK_JR   = 3'd2,
        XK_JMP  = 3'd3,
        XK_ERET = 3'd4
    } xfer_kind_e;

endpackage

// File: rtl/ctrl_xfer_decode.sv
// Combinational classifier for the instruction in ID: reports which kind of
// control transfer it is and whether it is taken. Holds no state.
module ctrl_xfer_decode
    import cpu_isa_pkg::*;
(
    input  logic       id_valid,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       rsrtequ,
    output logic       taken,
    output xfer_kind_e kind
);

    // Decode opcode/function and resolve branch condition for live instructions only
    always_comb begin
        taken = 1'b0;
        kind  = XK_NONE;
        if (id_valid) begin
            case (op)
                OP_J, OP_JAL: begin
                    taken = 1'b1;
                    kind  = XK_JMP;
                end
                OP_BEQ: begin
                    taken = rsrtequ;
                    kind  = XK_BR;
                end
                OP_BNE: begin
                    taken = ~rsrtequ;
                    kind  = XK_BR;
                end
                OP_SPECIAL: begin
                    if (func == FN_JR) begin
                        taken = 1'b1;
                        kind  = XK_JR;
                    end else begin
                        taken = 1'b0;
                        kind  = XK_NONE;
                    end
                end
                OP_COP0: begin
                    if (func == FN_ERET) begin
                        taken = 1'b1;
                        kind  = XK_ERET;
                    end else begin
                        taken = 1'b0;
                        kind  = XK_NONE;
                    end
                end
                default: begin
                    taken = 1'b0;
                    kind  = XK_NONE;
                end
            endcase
        end else begin
            taken = 1'b0;
            kind  = XK_NONE;
        end
    end

endmodule

// File: rtl/pc_ctrl_unit.sv
// Fetch-stage PC register and next-PC selection. Resolves ID-stage jumps and
// branches, exception entry/return with EPC, stall hold, IF flush and a
// saturating count of accepted redirects.
module pc_ctrl_unit
    import cpu_isa_pkg::*;
#(
    parameter int          AW       = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_0008,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic [AW-1:0]    id_pc,
    input  logic             rsrtequ,
    input  logic [AW-1:0]    rs_data,
    input  logic             exc_req,
    input  logic [AW-1:0]    exc_pc,
    output logic [AW-1:0]    pc,
    output logic [1:0]       pcsource,
    output logic             flush,
    output logic             exc_ack,
    output logic             in_exc,
    output logic [AW-1:0]    epc,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [AW-1:0] RESET_PC_L = RESET_PC[AW-1:0];
    localparam logic [AW-1:0] EXC_VEC_L  = EXC_VEC[AW-1:0];
    // Keeps the region bits above the 28-bit jump field (none when AW is 28)
    localparam logic [AW-1:0] HI_MASK    = ~AW'({28{1'b1}});

    logic [AW-1:0]    pc_r;
    logic [AW-1:0]    epc_r;
    logic             in_exc_r;
    logic [CNT_W-1:0] redirect_cnt_r;

    logic [AW-1:0]    seq_s;
    logic [AW-1:0]    id_pc4_s;
    logic [AW-1:0]    br_s;
    logic [AW-1:0]    jmp_s;
    logic [AW-1:0]    next_pc_s;
    logic [1:0]       pcsource_s;
    logic             flush_s;
    logic             exc_ack_s;
    logic             exc_take_s;
    logic             redirect_s;
    logic             eret_s;
    logic             taken_s;
    xfer_kind_e       kind_s;

    ctrl_xfer_decode u_decode (
        .id_valid (id_valid),
        .op       (id_inst[31:26]),
        .func     (id_inst[5:0]),
        .rsrtequ  (rsrtequ),
        .taken    (taken_s),
        .kind     (kind_s)
    );

    // Candidate targets; all arithmetic wraps at AW bits
    assign seq_s      = pc_r + AW'(32'd4);
    assign id_pc4_s   = id_pc + AW'(32'd4);
    assign br_s       = id_pc4_s + AW'({{14{id_inst[15]}}, id_inst[15:0], 2'b00});
    assign jmp_s      = (id_pc4_s & HI_MASK) | AW'({id_inst[25:0], 2'b00});
    // A pending exception is masked while the handler runs
    assign exc_take_s = exc_req & ~in_exc_r;

    // Next-PC priority: reset, exception, stall hold, ID redirect, sequential
    always_comb begin
        next_pc_s  = seq_s;
        pcsource_s = PCS_SEQ;
        flush_s    = 1'b0;
        exc_ack_s  = 1'b0;
        redirect_s = 1'b0;
        eret_s     = 1'b0;
        if (reset) begin
            next_pc_s = RESET_PC_L;
        end else if (exc_take_s) begin
            next_pc_s = EXC_VEC_L;
            flush_s   = 1'b1;
            exc_ack_s = 1'b1;
        end else if (stall) begin
            next_pc_s = pc_r;
        end else if (taken_s) begin
            flush_s    = 1'b1;
            redirect_s = 1'b1;
            case (kind_s)
                XK_BR: begin
                    next_pc_s  = br_s;
                    pcsource_s = PCS_BR;
                end
                XK_JR: begin
                    next_pc_s  = rs_data;
                    pcsource_s = PCS_JR;
                end
                XK_JMP: begin
                    next_pc_s  = jmp_s;
                    pcsource_s = PCS_JMP;
                end
                XK_ERET: begin
                    next_pc_s = epc_r;
                    eret_s    = 1'b1;
                end
                default: begin
                    next_pc_s  = seq_s;
                    flush_s    = 1'b0;
                    redirect_s = 1'b0;
                end
            endcase
        end else begin
            next_pc_s = seq_s;
        end
    end

    // PC, exception context and redirect counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r           <= RESET_PC_L;
            epc_r          <= '0;
            in_exc_r       <= 1'b0;
            redirect_cnt_r <= '0;
        end else begin
            pc_r <= next_pc_s;
            if (exc_take_s) begin
                epc_r    <= exc_pc;
                in_exc_r <= 1'b1;
            end else if (eret_s) begin
                in_exc_r <= 1'b0;
            end else begin
                in_exc_r <= in_exc_r;
            end
            if (redirect_s && (redirect_cnt_r != {CNT_W{1'b1}})) begin
                redirect_cnt_r <= redirect_cnt_r + CNT_W'(1'b1);
            end else begin
                redirect_cnt_r <= redirect_cnt_r;
            end
        end
    end

    assign pc           = pc_r;
    assign epc          = epc_r;
    assign in_exc       = in_exc_r;
    assign redirect_cnt = redirect_cnt_r;
    assign pcsource     = pcsource_s;
    assign flush        = flush_s;
    assign exc_ack      = exc_ack_s;

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Bench for pc_ctrl_unit: directed scenarios followed by random traffic, all
// checked against a behavioural next-PC model. A second instance with a 2-bit
// counter covers redirect-counter saturation.
module tb_pc_ctrl_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        rsrtequ;
    logic [31:0] rs_data;
    logic        exc_req;
    logic [31:0] exc_pc;

    logic [31:0] pc,  pc2;
    logic [1:0]  pcsource, pcsource2;
    logic        flush, flush2;
    logic        exc_ack, exc_ack2;
    logic        in_exc, in_exc2;
    logic [31:0] epc, epc2;
    logic [15:0] redirect_cnt;
    logic [1:0]  redirect_cnt2;

    int n_tests;
    int n_fail;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_in_exc;
    int          m_cnt;

    pc_ctrl_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .id_valid(id_valid),
        .id_inst(id_inst), .id_pc(id_pc), .rsrtequ(rsrtequ), .rs_data(rs_data),
        .exc_req(exc_req), .exc_pc(exc_pc), .pc(pc), .pcsource(pcsource),
        .flush(flush), .exc_ack(exc_ack), .in_exc(in_exc), .epc(epc),
        .redirect_cnt(redirect_cnt)
    );

    pc_ctrl_unit #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .stall(stall), .id_valid(id_valid),
        .id_inst(id_inst), .id_pc(id_pc), .rsrtequ(rsrtequ), .rs_data(rs_data),
        .exc_req(exc_req), .exc_pc(exc_pc), .pc(pc2), .pcsource(pcsource2),
        .flush(flush2), .exc_ack(exc_ack2), .in_exc(in_exc2), .epc(epc2),
        .redirect_cnt(redirect_cnt2)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check combinational outputs against the model,
    // clock it, then check the registered state.
    task automatic run_cycle(input logic r, input logic st, input logic v,
                             input logic [31:0] inst, input logic [31:0] ipc,
                             input logic eq, input logic [31:0] rs,
                             input logic ex, input logic [31:0] xpc);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] e_pcs;
        logic        e_flush, e_ack;
        logic [31:0] n_pc, n_epc, t_pc;
        logic        n_in;
        int          n_cnt, off, k;
        reset = r; stall = st; id_valid = v; id_inst = inst; id_pc = ipc;
        rsrtequ = eq; rs_data = rs; exc_req = ex; exc_pc = xpc;
        #2;
        op = inst[31:26];
        fn = inst[5:0];
        off = $signed(inst[15:0]);
        // k: 0 none, 1 branch, 2 jr, 3 jump, 4 eret
        k = 0;
        if (v) begin
            if ((op == 6'd2) || (op == 6'd3)) k = 3;
            else if (op == 6'd4 && eq) k = 1;
            else if (op == 6'd5 && !eq) k = 1;
            else if (op == 6'd0 && fn == 6'd8) k = 2;
            else if (op == 6'd16 && fn == 6'd24) k = 4;
        end
        e_pcs = 32'd0; e_flush = 1'b0; e_ack = 1'b0;
        n_pc = m_pc + 32'd4; n_epc = m_epc; n_in = m_in_exc; n_cnt = m_cnt;
        if (r) begin
            n_pc = 32'd0; n_epc = 32'd0; n_in = 1'b0; n_cnt = 0;
        end else if (ex && !m_in_exc) begin
            n_pc = 32'h8; n_epc = xpc; n_in = 1'b1; e_flush = 1'b1; e_ack = 1'b1;
        end else if (st) begin
            n_pc = m_pc;
        end else if (k != 0) begin
            e_flush = 1'b1;
            n_cnt = m_cnt + 1;
            if (k == 1) begin
                t_pc = ipc + 32'd4 + 32'(off * 4);
                e_pcs = 32'd1;
            end else if (k == 2) begin
                t_pc = rs;
                e_pcs = 32'd2;
            end else if (k == 3) begin
                t_pc = ((ipc + 32'd4) & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
                e_pcs = 32'd3;
            end else begin
                t_pc = m_epc;
                n_in = 1'b0;
            end
            n_pc = t_pc;
        end
        check_val("flush", {31'd0, flush}, {31'd0, e_flush});
        check_val("pcsource", {30'd0, pcsource}, e_pcs);
        check_val("exc_ack", {31'd0, exc_ack}, {31'd0, e_ack});
        @(posedge clock);
        #1;
        m_pc = n_pc; m_epc = n_epc; m_in_exc = n_in; m_cnt = n_cnt;
        check_val("pc", pc, m_pc);
        check_val("epc", epc, m_epc);
        check_val("in_exc", {31'd0, in_exc}, {31'd0, m_in_exc});
        check_val("cnt16", {16'd0, redirect_cnt}, (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
        check_val("cnt2", {30'd0, redirect_cnt2}, (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
        check_val("pc_sat_inst", pc2, m_pc);
    endtask

    // Plain sequential cycle with nothing live in ID
    task automatic idle_cycle(input logic r);
        run_cycle(r, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    localparam logic [31:0] BEQ_3    = {6'd4, 5'd1, 5'd2, 16'h0003};
    localparam logic [31:0] BNE_M1   = {6'd5, 5'd1, 5'd2, 16'hFFFF};
    localparam logic [31:0] J_40     = {6'd2, 26'h0000040};
    localparam logic [31:0] JR_31    = {6'd0, 5'd31, 15'd0, 6'd8};
    localparam logic [31:0] ERET_I   = {6'd16, 1'b1, 19'd0, 6'd24};

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [31:0] rnd, inst;
        int sel;
        n_tests = 0; n_fail = 0;
        m_pc = 32'd0; m_epc = 32'd0; m_in_exc = 1'b0; m_cnt = 0;
        reset = 1'b1; stall = 1'b0; id_valid = 1'b0; id_inst = 32'd0; id_pc = 32'd0;
        rsrtequ = 1'b0; rs_data = 32'd0; exc_req = 1'b0; exc_pc = 32'd0;

        idle_cycle(1'b1);
        idle_cycle(1'b1);
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_in_exc", {31'd0, in_exc}, 32'd0);
        check_val("rst_cnt", {16'd0, redirect_cnt}, 32'd0);
        idle_cycle(1'b0);
        check_val("seq_pc4", pc, 32'h4);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        check_val("seq_pcC", pc, 32'hC);

        run_cycle(1'b0, 1'b0, 1'b1, BEQ_3, 32'h10, 1'b1, 32'd0, 1'b0, 32'd0);
        check_val("beq_taken_pc", pc, 32'h20);
        check_val("beq_cnt", {16'd0, redirect_cnt}, 32'd1);
        run_cycle(1'b0, 1'b0, 1'b1, BEQ_3, 32'h10, 1'b0, 32'd0, 1'b0, 32'd0);
        check_val("beq_ntaken_pc", pc, 32'h24);
        run_cycle(1'b0, 1'b0, 1'b1, BNE_M1, 32'h40, 1'b0, 32'd0, 1'b0, 32'd0);
        check_val("bne_back_pc", pc, 32'h40);
        run_cycle(1'b0, 1'b0, 1'b1, J_40, 32'h1000_0000, 1'b0, 32'd0, 1'b0, 32'd0);
        check_val("j_pc", pc, 32'h1000_0100);
        run_cycle(1'b0, 1'b0, 1'b1, JR_31, 32'h80, 1'b0, 32'h200, 1'b0, 32'd0);
        check_val("jr_pc", pc, 32'h200);

        run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h24);
        check_val("exc_pc", pc, 32'h8);
        check_val("exc_epc", epc, 32'h24);
        run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h99);
        check_val("exc2_epc", epc, 32'h24);
        run_cycle(1'b0, 1'b0, 1'b1, ERET_I, 32'h8, 1'b0, 32'd0, 1'b0, 32'd0);
        check_val("eret_pc", pc, 32'h24);
        check_val("eret_in_exc", {31'd0, in_exc}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b1, 1'b1, BEQ_3, 32'h10, 1'b1, 32'd0, 1'b0, 32'd0);
        end
        check_val("stall_pc", pc, 32'h24);
        run_cycle(1'b0, 1'b0, 1'b1, BEQ_3, 32'h10, 1'b1, 32'd0, 1'b0, 32'd0);
        check_val("unstall_pc", pc, 32'h20);
        check_val("cnt_sat2", {30'd0, redirect_cnt2}, 32'd3);
        check_val("cnt_full", {16'd0, redirect_cnt}, 32'd6);

        run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h44);
        idle_cycle(1'b1);
        check_val("rst_mid_pc", pc, 32'h0);
        check_val("rst_mid_epc", epc, 32'h0);
        check_val("rst_mid_in_exc", {31'd0, in_exc}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: inst = {6'd2, rnd[25:0]};
                1: inst = {6'd3, rnd[25:0]};
                2: inst = {6'd4, rnd[25:0]};
                3: inst = {6'd5, rnd[25:0]};
                4: inst = {6'd0, rnd[25:6], 6'd8};
                5: inst = {6'd16, rnd[25:6], 6'd24};
                default: inst = $urandom;
            endcase
            run_cycle(($urandom_range(0, 63) == 0),
                      ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 4) != 0),
                      inst, $urandom, 1'($urandom), $urandom,
                      ($urandom_range(0, 7) == 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
